// File: rtl/add_post_norm_if.sv
`default_nettype none
// ============================================================================
//  Module      : add_post_norm_if
//  Description : Operand/result handshake bundle for the floating-point
//                adder post-normalisation and rounding stage.
//  Revision    : 1.0 - initial release
// ============================================================================
interface add_post_norm_if;
    // Operand side
    logic        in_valid;
    logic        in_ready;
    logic [27:0] fract_in;
    logic [7:0]  exp_in;
    logic        sign_in;
    logic        zero_sign;
    logic [1:0]  rmode;

    // Result side
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow;
    logic        underflow;
    logic        inexact;

    // Producer of operands / consumer of results
    modport master (
        output in_valid, fract_in, exp_in, sign_in, zero_sign, rmode, out_ready,
        input  in_ready, out_valid, result, overflow, underflow, inexact
    );

    // The post-normalisation block itself
    modport slave (
        input  in_valid, fract_in, exp_in, sign_in, zero_sign, rmode, out_ready,
        output in_ready, out_valid, result, overflow, underflow, inexact
    );
endinterface
`default_nettype wire

// File: rtl/add_post_norm.sv
`default_nettype none
// ============================================================================
//  Module      : add_post_norm
//  Description : Post-normalisation and rounding of a raw single-precision
//                add/sub result. Carries are removed with one right shift,
//                cancellations with one left shift per cycle, then the
//                24-bit mantissa is rounded in one of four IEEE modes and
//                packed together with overflow/underflow/inexact flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module add_post_norm (
    input  logic           clk,
    input  logic           rst_n,
    add_post_norm_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [1:0]  S_IDLE      = 2'd0;
    localparam logic [1:0]  S_NORM      = 2'd1;
    localparam logic [1:0]  S_ROUND     = 2'd2;
    localparam logic [1:0]  S_OUT       = 2'd3;

    localparam logic [1:0]  C_RM_NEAR   = 2'd0;
    localparam logic [1:0]  C_RM_ZERO   = 2'd1;
    localparam logic [1:0]  C_RM_PINF   = 2'd2;

    // Exponent is kept 10 bits wide so a carry out of 254/255 plus a
    // rounding carry never wraps before the overflow test.
    localparam logic [9:0]  C_EXP_LIMIT = 10'd255;
    localparam logic [30:0] C_INF_MAG   = 31'h7F80_0000;
    localparam logic [30:0] C_MAX_MAG   = 31'h7F7F_FFFF;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]  r_state;
    logic [27:0] r_fract;
    logic [9:0]  r_exp;
    logic        r_sticky;
    logic        r_sign;
    logic        r_zero_sign;
    logic [1:0]  r_rmode;

    logic        r_out_valid;
    logic [31:0] r_result;
    logic        r_overflow;
    logic        r_underflow;
    logic        r_inexact;

    // ------------------------------------------------------------------------
    // Normalisation step decisions
    // ------------------------------------------------------------------------
    logic w_carry;
    logic w_shift_left;

    // A carry always wins; a left shift is only allowed while the value is
    // non-zero, unnormalised and the exponent can still be decremented.
    assign w_carry      = r_fract[27];
    assign w_shift_left = ~r_fract[26] & (r_fract != 28'd0) & (r_exp > 10'd1);

    // ------------------------------------------------------------------------
    // Rounding datapath
    // ------------------------------------------------------------------------
    logic [23:0] w_mant;
    logic        w_g;
    logic        w_r;
    logic        w_s;
    logic        w_any;
    logic        w_inc;
    logic [24:0] w_sum;
    logic [23:0] w_mant_rnd;
    logic [9:0]  w_exp_rnd;
    logic [7:0]  w_exp_field;
    logic        w_ovf;
    logic        w_to_inf;
    logic        w_is_zero;

    // Round the normalised mantissa and renormalise a rounding carry.
    always_comb begin
        w_mant = r_fract[26:3];
        w_g    = r_fract[2];
        w_r    = r_fract[1];
        w_s    = r_fract[0] | r_sticky;
        w_any  = w_g | w_r | w_s;
        w_inc  = 1'b0;

        case (r_rmode)
            C_RM_NEAR: w_inc = w_g & (w_r | w_s | w_mant[0]);
            C_RM_ZERO: w_inc = 1'b0;
            C_RM_PINF: w_inc = w_any & ~r_sign;
            default:   w_inc = w_any & r_sign;
        endcase

        w_sum = {1'b0, w_mant} + {24'd0, w_inc};

        if (w_sum[24]) begin
            w_mant_rnd = w_sum[24:1];
            w_exp_rnd  = r_exp + 10'd1;
        end else begin
            w_mant_rnd = w_sum[23:0];
            w_exp_rnd  = r_exp;
        end

        // Without the hidden bit the value is denormal and the biased
        // exponent field is 0; a denormal that rounds up into bit 23
        // naturally picks up E (which is 1 in that case).
        w_exp_field = w_mant_rnd[23] ? w_exp_rnd[7:0] : 8'd0;
        w_ovf       = (w_exp_rnd >= C_EXP_LIMIT);
        w_is_zero   = (r_fract == 28'd0) & ~r_sticky;
    end

    logic [31:0] w_result;
    logic        w_res_ovf;
    logic        w_res_unf;
    logic        w_res_inx;

    // Select the packed result: exact zero, saturated overflow or normal.
    always_comb begin
        case (r_rmode)
            C_RM_NEAR: w_to_inf = 1'b1;
            C_RM_ZERO: w_to_inf = 1'b0;
            C_RM_PINF: w_to_inf = ~r_sign;
            default:   w_to_inf = r_sign;
        endcase

        w_result  = {r_sign, w_exp_field, w_mant_rnd[22:0]};
        w_res_ovf = 1'b0;
        w_res_unf = 1'b0;
        w_res_inx = w_any;

        if (w_is_zero) begin
            w_result  = {r_zero_sign, 31'h0};
            w_res_inx = 1'b0;
        end else if (w_ovf) begin
            w_res_ovf = 1'b1;
            w_res_inx = 1'b1;
            w_result  = w_to_inf ? {r_sign, C_INF_MAG} : {r_sign, C_MAX_MAG};
        end else begin
            w_res_unf = (w_exp_field == 8'd0) & w_any;
        end
    end

    // ------------------------------------------------------------------------
    // Sequencing
    // ------------------------------------------------------------------------

    // Control FSM plus the iterative normalisation shifter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fract     <= 28'd0;
            r_exp       <= 10'd0;
            r_sticky    <= 1'b0;
            r_sign      <= 1'b0;
            r_zero_sign <= 1'b0;
            r_rmode     <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_fract     <= bus.fract_in;
                        r_exp       <= (bus.exp_in == 8'd0) ? 10'd1 : {2'b00, bus.exp_in};
                        r_sticky    <= 1'b0;
                        r_sign      <= bus.sign_in;
                        r_zero_sign <= bus.zero_sign;
                        r_rmode     <= bus.rmode;
                        r_state     <= S_NORM;
                    end
                end
                S_NORM: begin
                    if (w_carry) begin
                        r_fract  <= {1'b0, r_fract[27:1]};
                        r_sticky <= r_sticky | r_fract[0];
                        r_exp    <= r_exp + 10'd1;
                        r_state  <= S_ROUND;
                    end else if (w_shift_left) begin
                        r_fract  <= {r_fract[26:0], 1'b0};
                        r_exp    <= r_exp - 10'd1;
                    end else begin
                        r_state  <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    r_state <= S_OUT;
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Capture the rounded result once and hold it until the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= 32'd0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_inexact   <= 1'b0;
        end else if (r_state == S_ROUND) begin
            r_out_valid <= 1'b1;
            r_result    <= w_result;
            r_overflow  <= w_res_ovf;
            r_underflow <= w_res_unf;
            r_inexact   <= w_res_inx;
        end else if ((r_state == S_OUT) && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.overflow  = r_overflow;
    assign bus.underflow = r_underflow;
    assign bus.inexact   = r_inexact;

endmodule
`default_nettype wire

// File: tb/tb_add_post_norm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_add_post_norm
//  Description : Self-checking bench for add_post_norm. A closed-form
//                reference model predicts result, flags and latency; a
//                compare process checks the DUT every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_add_post_norm;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    add_post_norm_if bus ();

    add_post_norm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [31:0] res;
        logic        ovf;
        logic        unf;
        logic        inx;
        logic [31:0] lat;
    } exp_t;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Closed-form reference: leading-one position gives the shift count
    // directly; rounding works on the 3-bit remainder as an integer.
    function automatic exp_t model(input logic [27:0] f, input logic [7:0] ein,
                                   input logic sg, input logic zs, input logic [1:0] rm);
        exp_t        o;
        int          e;
        int          l;
        int          msb;
        int          mant;
        int          rem;
        int          inc;
        logic [27:0] fr;
        bit          to_inf;
        o     = '0;
        o.lat = 2;
        if (f == 28'd0) begin
            o.res = {zs, 31'h0};
            return o;
        end
        e   = (ein == 8'd0) ? 1 : int'(ein);
        rem = 0;
        if (f[27]) begin
            fr  = f >> 1;
            e   = e + 1;
            rem = int'(f[0]);
        end else begin
            msb = 0;
            for (int i = 0; i < 27; i++) if (f[i]) msb = i;
            l = 26 - msb;
            if (l > e - 1) l = e - 1;
            fr = f << l;
            e  = e - l;
            if (l > 0) o.lat = l + 2;
        end
        mant = int'(fr[26:3]);
        rem  = rem | int'(fr[2:0]);
        case (rm)
            2'd0:    inc = (rem > 4 || (rem == 4 && (mant % 2) == 1)) ? 1 : 0;
            2'd1:    inc = 0;
            2'd2:    inc = (rem != 0 && !sg) ? 1 : 0;
            default: inc = (rem != 0 && sg) ? 1 : 0;
        endcase
        mant = mant + inc;
        if (mant == (1 << 24)) begin
            mant = mant / 2;
            e    = e + 1;
        end
        if (e >= 255) begin
            to_inf = (rm == 2'd0) || (rm == 2'd2 && !sg) || (rm == 2'd3 && sg);
            o.res  = to_inf ? {sg, 31'h7F800000} : {sg, 31'h7F7FFFFF};
            o.ovf  = 1'b1;
            o.inx  = 1'b1;
        end else begin
            o.inx = (rem != 0);
            if (mant >= (1 << 23)) begin
                o.res = {sg, e[7:0], mant[22:0]};
            end else begin
                o.res = {sg, 8'd0, mant[22:0]};
                o.unf = o.inx;
            end
        end
        return o;
    endfunction

    // ------------------------------------------------------------------------
    // Compare process: one operation in flight at most
    // ------------------------------------------------------------------------
    bit   pending = 0;
    bit   seen    = 0;
    exp_t cur;
    int   ncyc    = 0;
    int   acc     = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pending = 0;
            seen    = 0;
        end else begin
            ncyc++;
            check("in_ready", bus.in_ready, !pending);
            if (pending) begin
                if (bus.out_valid) begin
                    if (!seen) begin
                        check("latency", ncyc - acc, cur.lat);
                        seen = 1;
                    end
                    check("result", bus.result, cur.res);
                    check("flags", {bus.overflow, bus.underflow, bus.inexact},
                          {cur.ovf, cur.unf, cur.inx});
                    if (bus.out_ready) begin
                        pending = 0;
                        seen    = 0;
                    end
                end
            end else begin
                check("out_valid_idle", bus.out_valid, 1'b0);
                if (bus.in_valid && bus.in_ready) begin
                    cur     = model(bus.fract_in, bus.exp_in, bus.sign_in, bus.zero_sign, bus.rmode);
                    pending = 1;
                    seen    = 0;
                    acc     = ncyc + 1;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------------
    task automatic drive_op(input logic [27:0] f, input logic [7:0] e, input logic sg,
                            input logic zs, input logic [1:0] rm);
        int t;
        t = 0;
        while (!bus.in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_wait", bus.in_ready, 1'b1);
        bus.in_valid  = 1'b1;
        bus.fract_in  = f;
        bus.exp_in    = e;
        bus.sign_in   = sg;
        bus.zero_sign = zs;
        bus.rmode     = rm;
        @(posedge clk); #1;
        // Garbage on the operand lines must not disturb the operation.
        bus.in_valid  = 1'b0;
        bus.fract_in  = 28'($urandom);
        bus.exp_in    = 8'($urandom);
        bus.sign_in   = 1'($urandom);
        bus.zero_sign = 1'($urandom);
        bus.rmode     = 2'($urandom);
    endtask

    task automatic finish_op(input int hold, output logic [31:0] res,
                             output logic [2:0] flg, output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("done_wait", bus.out_valid, 1'b1);
        res = bus.result;
        flg = {bus.overflow, bus.underflow, bus.inexact};
        repeat (hold) begin
            @(posedge clk); #1;
        end
        if (hold > 0) check("hold_in_ready", bus.in_ready, 1'b0);
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic directed(input string nm, input logic [27:0] f, input logic [7:0] e,
                            input logic sg, input logic zs, input logic [1:0] rm, input int hold,
                            input logic [31:0] x_res, input logic [2:0] x_flg, input int x_lat);
        exp_t        m;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        m = model(f, e, sg, zs, rm);
        check({nm, "_model"}, {m.res, m.ovf, m.unf, m.inx, m.lat[7:0]},
              {x_res, x_flg, 8'(x_lat)});
        drive_op(f, e, sg, zs, rm);
        finish_op(hold, res, flg, lat);
        check({nm, "_result"}, res, x_res);
        check({nm, "_flags"}, flg, x_flg);
        check({nm, "_latency"}, lat, x_lat);
    endtask

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        logic [27:0] f;
        logic [7:0]  e;
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.fract_in  = 28'd0;
        bus.exp_in    = 8'd0;
        bus.sign_in   = 1'b0;
        bus.zero_sign = 1'b0;
        bus.rmode     = 2'd0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", bus.in_ready, 1'b1);
        check("reset_out_valid", bus.out_valid, 1'b0);
        check("reset_result", bus.result, 32'h0);
        check("reset_flags", {bus.overflow, bus.underflow, bus.inexact}, 3'b000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Flags are ordered {overflow, underflow, inexact}.
        directed("carry",      28'h8000000, 8'd127, 1'b0, 1'b0, 2'd0, 10, 32'h40000000, 3'b000, 2);
        directed("cancel",     28'h0000008, 8'd127, 1'b0, 1'b0, 2'd0, 0,  32'h34000000, 3'b000, 25);
        directed("tie_even",   28'h4000004, 8'd127, 1'b0, 1'b0, 2'd0, 1,  32'h3F800000, 3'b001, 2);
        directed("tie_odd",    28'h400000C, 8'd127, 1'b0, 1'b0, 2'd0, 0,  32'h3F800002, 3'b001, 2);
        directed("trunc",      28'h400000C, 8'd127, 1'b0, 1'b0, 2'd1, 2,  32'h3F800001, 3'b001, 2);
        directed("ovf_rne",    28'h8000000, 8'd254, 1'b0, 1'b0, 2'd0, 0,  32'h7F800000, 3'b101, 2);
        directed("ovf_rtz",    28'h8000000, 8'd254, 1'b0, 1'b0, 2'd1, 0,  32'h7F7FFFFF, 3'b101, 2);
        directed("ovf_pinf_n", 28'h8000000, 8'd254, 1'b1, 1'b0, 2'd2, 0,  32'hFF7FFFFF, 3'b101, 2);
        directed("zero",       28'h0000000, 8'd100, 1'b0, 1'b1, 2'd0, 0,  32'h80000000, 3'b000, 2);
        directed("denorm",     28'h0000014, 8'd0,   1'b0, 1'b0, 2'd0, 3,  32'h00000002, 3'b011, 2);

        // Reset in the middle of a long cancellation.
        drive_op(28'h0000008, 8'd127, 1'b0, 1'b0, 2'd0);
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_result", bus.result, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("postrst_out_valid", bus.out_valid, 1'b0);
        directed("after_rst",  28'h8000000, 8'd127, 1'b0, 1'b0, 2'd0, 0,  32'h40000000, 3'b000, 2);

        // Randomised operands across carry, normalised, cancellation and zero.
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0:       f = 28'd0;
                1, 2:    f = {1'b1, 27'($urandom)};
                3, 4:    f = {2'b01, 26'($urandom)};
                default: f = 28'($urandom) >> $urandom_range(0, 27);
            endcase
            case ($urandom_range(0, 7))
                0:       e = 8'd0;
                1:       e = 8'd1;
                2:       e = 8'd254;
                3:       e = 8'd255;
                default: e = 8'($urandom);
            endcase
            drive_op(f, e, 1'($urandom), 1'($urandom), 2'($urandom));
            finish_op($urandom_range(0, 3), res, flg, lat);
        end

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog against a hung handshake.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
